// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter between the instruction and data ports. Grants one
// requester, decodes it onto BRAM/UART/CLINT/PLIC and returns the response.
module mem_bus_arbiter #(
  parameter logic [31:0] bram_base_addr  = 32'h0000_0000,
  parameter logic [31:0] bram_top_addr   = 32'h0000_2000,
  parameter logic [31:0] uart_base_addr  = 32'h0100_0000,
  parameter logic [31:0] uart_top_addr   = 32'h0100_0004,
  parameter logic [31:0] clint_base_addr = 32'h0200_0000,
  parameter logic [31:0] clint_top_addr  = 32'h0200_C000,
  parameter logic [31:0] plic_base_addr  = 32'h0C00_0000,
  parameter logic [31:0] plic_top_addr   = 32'h1000_0000,
  parameter int unsigned timeout_cycles  = 255
) (
  input  logic         clock,
  input  logic         reset,

  input  logic         imem_valid,
  input  logic [31:0]  imem_addr,
  output logic [31:0]  imem_rdata,
  output logic         imem_ready,
  output logic         imem_error,

  input  logic         dmem_valid,
  input  logic [31:0]  dmem_addr,
  input  logic [31:0]  dmem_wdata,
  input  logic [3:0]   dmem_wstrb,
  output logic [31:0]  dmem_rdata,
  output logic         dmem_ready,
  output logic         dmem_error,

  output logic [31:0]  slv_addr,
  output logic [31:0]  slv_wdata,
  output logic [3:0]   slv_wstrb,
  output logic [3:0]   slv_valid,
  input  logic [127:0] slv_rdata,
  input  logic [3:0]   slv_ready
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [15:0] timeout_last = 16'(timeout_cycles - 1);

  state_t      state;
  logic        grant_data;
  logic        rr_last_data;
  logic [15:0] count;

  logic        both_valid;
  logic        pick_data;
  logic [31:0] req_addr;
  logic [3:0]  req_hit;
  logic [31:0] sel_rdata;
  logic        sel_ready;

  // Offset compare is equivalent to base <= a < top for base <= top and
  // avoids a constant-true compare when a window starts at address 0.
  function automatic logic in_window(input logic [31:0] a,
                                     input logic [31:0] base,
                                     input logic [31:0] top);
    return (a - base) < (top - base);
  endfunction

  function automatic logic [3:0] decode(input logic [31:0] a);
    logic [3:0] hit;
    hit[0] = in_window(a, bram_base_addr,  bram_top_addr);
    hit[1] = in_window(a, uart_base_addr,  uart_top_addr);
    hit[2] = in_window(a, clint_base_addr, clint_top_addr);
    hit[3] = in_window(a, plic_base_addr,  plic_top_addr);
    return hit;
  endfunction

  // Round-robin only applies to contended cycles: a lone requester is
  // granted without disturbing the tie-break history.
  always_comb begin
    both_valid = imem_valid && dmem_valid;
    pick_data  = dmem_valid && (!imem_valid || !rr_last_data);
    req_addr   = pick_data ? dmem_addr : imem_addr;
    req_hit    = decode(req_addr);
  end

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (slv_valid[i]) sel_rdata = sel_rdata | slv_rdata[32*i +: 32];
    end
    sel_ready = |(slv_valid & slv_ready);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      grant_data   <= 1'b0;
      rr_last_data <= 1'b1;
      count        <= '0;
      slv_addr     <= '0;
      slv_wdata    <= '0;
      slv_wstrb    <= '0;
      slv_valid    <= '0;
      imem_rdata   <= '0;
      imem_ready   <= 1'b0;
      imem_error   <= 1'b0;
      dmem_rdata   <= '0;
      dmem_ready   <= 1'b0;
      dmem_error   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (imem_valid || dmem_valid) begin
            grant_data <= pick_data;
            if (both_valid) rr_last_data <= pick_data;
            slv_addr  <= req_addr;
            slv_wdata <= pick_data ? dmem_wdata : '0;
            slv_wstrb <= pick_data ? dmem_wstrb : '0;
            count     <= '0;
            if (|req_hit) begin
              slv_valid <= req_hit;
              state     <= ACCESS;
            end else begin
              if (pick_data) begin
                dmem_ready <= 1'b1;
                dmem_error <= 1'b1;
                dmem_rdata <= '0;
              end else begin
                imem_ready <= 1'b1;
                imem_error <= 1'b1;
                imem_rdata <= '0;
              end
              state <= RESP;
            end
          end
        end

        ACCESS: begin
          // A ready on the final allowed cycle takes priority over timeout.
          if (sel_ready || count == timeout_last) begin
            slv_valid <= '0;
            if (grant_data) begin
              dmem_ready <= 1'b1;
              dmem_error <= !sel_ready;
              dmem_rdata <= sel_ready ? sel_rdata : '0;
            end else begin
              imem_ready <= 1'b1;
              imem_error <= !sel_ready;
              imem_rdata <= sel_ready ? sel_rdata : '0;
            end
            state <= RESP;
          end else begin
            count <= count + 16'd1;
          end
        end

        RESP: begin
          imem_ready <= 1'b0;
          imem_error <= 1'b0;
          imem_rdata <= '0;
          dmem_ready <= 1'b0;
          dmem_error <= 1'b0;
          dmem_rdata <= '0;
          count      <= '0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: arbitration, decode windows, timeout,
// latency and asynchronous reset, with constant expected values.
module tb_mem_bus_arbiter;

  localparam int unsigned timeout_cfg = 8;
  localparam logic [31:0] bram_data  = 32'hDEAD_BEEF;
  localparam logic [31:0] uart_data  = 32'h0000_0055;
  localparam logic [31:0] clint_data = 32'h1234_5678;
  localparam logic [31:0] plic_data  = 32'hCAFE_0001;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         imem_valid = 1'b0;
  logic [31:0]  imem_addr = '0;
  logic [31:0]  imem_rdata;
  logic         imem_ready;
  logic         imem_error;
  logic         dmem_valid = 1'b0;
  logic [31:0]  dmem_addr = '0;
  logic [31:0]  dmem_wdata = '0;
  logic [3:0]   dmem_wstrb = '0;
  logic [31:0]  dmem_rdata;
  logic         dmem_ready;
  logic         dmem_error;
  logic [31:0]  slv_addr;
  logic [31:0]  slv_wdata;
  logic [3:0]   slv_wstrb;
  logic [3:0]   slv_valid;
  logic [127:0] slv_rdata;
  logic [3:0]   slv_ready;

  logic [3:0]   ready_en = 4'b1111;
  logic         late_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  // Each slave answers in the first ACCESS cycle unless masked by ready_en.
  assign slv_ready = slv_valid & (ready_en | {4{late_ready}});
  assign slv_rdata = {plic_data, clint_data, uart_data, bram_data};

  always #5 clock = ~clock;

  mem_bus_arbiter #(
    .timeout_cycles(timeout_cfg)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .imem_valid (imem_valid),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .imem_error (imem_error),
    .dmem_valid (dmem_valid),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_wstrb (dmem_wstrb),
    .dmem_rdata (dmem_rdata),
    .dmem_ready (dmem_ready),
    .dmem_error (dmem_error),
    .slv_addr   (slv_addr),
    .slv_wdata  (slv_wdata),
    .slv_wstrb  (slv_wstrb),
    .slv_valid  (slv_valid),
    .slv_rdata  (slv_rdata),
    .slv_ready  (slv_ready)
  );

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  // Runs one request to completion. edges counts clock edges from the first
  // edge that samples valid to the edge after which ready is visible
  // (-1 if it never arrives). Ends back in IDLE with both valids low.
  task automatic do_req(input  logic        is_data,
                        input  logic [31:0] addr,
                        input  logic [31:0] wdata,
                        input  logic [3:0]  wstrb,
                        input  int          ready_at,
                        output int          edges,
                        output int          valid_cycles,
                        output logic [3:0]  seen,
                        output logic [31:0] rdata,
                        output logic        err,
                        output logic        other_ready);
    logic done;
    edges = 0; valid_cycles = 0; seen = '0; rdata = '0; err = 1'b0;
    other_ready = 1'b0; done = 1'b0;
    if (is_data) begin
      dmem_valid = 1'b1; dmem_addr = addr; dmem_wdata = wdata; dmem_wstrb = wstrb;
    end else begin
      imem_valid = 1'b1; imem_addr = addr;
    end
    for (int i = 0; i < 50 && !done; i++) begin
      step;
      edges++;
      seen = seen | slv_valid;
      if (slv_valid != 4'b0000) valid_cycles++;
      late_ready = (ready_at != 0) && (valid_cycles == ready_at);
      other_ready = other_ready | (is_data ? imem_ready : dmem_ready);
      if (is_data ? dmem_ready : imem_ready) begin
        rdata = is_data ? dmem_rdata : imem_rdata;
        err   = is_data ? dmem_error : imem_error;
        done  = 1'b1;
      end
    end
    if (!done) edges = -1;
    imem_valid = 1'b0;
    dmem_valid = 1'b0;
    late_ready = 1'b0;
    step;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    step;
    step;
    checks++;
    if ({imem_ready, imem_error, dmem_ready, dmem_error} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000", {imem_ready, imem_error, dmem_ready, dmem_error});
    end
    checks++;
    if (slv_valid !== 4'b0000 || slv_wstrb !== 4'b0000) begin
      errors++;
      $display("FAIL reset_slv got valid=%b wstrb=%b want 0000/0000", slv_valid, slv_wstrb);
    end
    checks++;
    if ({slv_addr, slv_wdata, imem_rdata, dmem_rdata} !== 128'd0) begin
      errors++;
      $display("FAIL reset_data got %h want 0", {slv_addr, slv_wdata, imem_rdata, dmem_rdata});
    end
    reset = 1'b1;
    step;
  endtask

  task automatic test_single_read;
    imem_valid = 1'b1;
    imem_addr  = 32'h100;
    step;
    checks++;
    if (slv_valid !== 4'b0001 || slv_addr !== 32'h100 || slv_wstrb !== 4'b0000) begin
      errors++;
      $display("FAIL single_access got valid=%b addr=%h wstrb=%b want 0001/100/0000", slv_valid, slv_addr, slv_wstrb);
    end
    step;
    checks++;
    if (imem_ready !== 1'b1 || imem_rdata !== bram_data || imem_error !== 1'b0 || dmem_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_resp got ready=%b rdata=%h err=%b dready=%b want 1/%h/0/0", imem_ready, imem_rdata, imem_error, dmem_ready, bram_data);
    end
    checks++;
    if (slv_valid !== 4'b0000) begin
      errors++;
      $display("FAIL single_valid_drop got %b want 0000", slv_valid);
    end
    imem_valid = 1'b0;
    step;
    checks++;
    if (imem_ready !== 1'b0 || imem_rdata !== 32'h0) begin
      errors++;
      $display("FAIL single_pulse got ready=%b rdata=%h want 0/0", imem_ready, imem_rdata);
    end
  endtask

  task automatic test_tie;
    imem_valid = 1'b1; imem_addr = 32'h0;
    dmem_valid = 1'b1; dmem_addr = 32'h0100_0000; dmem_wdata = 32'h41; dmem_wstrb = 4'b0001;
    step;
    checks++;
    if (slv_valid !== 4'b0001 || slv_addr !== 32'h0 || slv_wstrb !== 4'b0000) begin
      errors++;
      $display("FAIL tie1_first got valid=%b addr=%h wstrb=%b want 0001/0/0000", slv_valid, slv_addr, slv_wstrb);
    end
    step;
    checks++;
    if (imem_ready !== 1'b1 || imem_rdata !== bram_data || dmem_ready !== 1'b0) begin
      errors++;
      $display("FAIL tie1_iresp got iready=%b rdata=%h dready=%b want 1/%h/0", imem_ready, imem_rdata, dmem_ready, bram_data);
    end
    imem_valid = 1'b0;
    step;
    step;
    checks++;
    if (slv_valid !== 4'b0010 || slv_wstrb !== 4'b0001 || slv_wdata !== 32'h41 || slv_addr !== 32'h0100_0000) begin
      errors++;
      $display("FAIL tie1_second got valid=%b wstrb=%b wdata=%h addr=%h want 0010/0001/41/1000000", slv_valid, slv_wstrb, slv_wdata, slv_addr);
    end
    step;
    checks++;
    if (dmem_ready !== 1'b1 || dmem_error !== 1'b0 || dmem_rdata !== uart_data || imem_ready !== 1'b0) begin
      errors++;
      $display("FAIL tie1_dresp got ready=%b err=%b rdata=%h iready=%b want 1/0/%h/0", dmem_ready, dmem_error, dmem_rdata, imem_ready, uart_data);
    end
    dmem_valid = 1'b0;
    step;
    // Instruction won the previous tie, so data wins this one.
    imem_valid = 1'b1; imem_addr = 32'h4;
    dmem_valid = 1'b1; dmem_addr = 32'h8; dmem_wstrb = 4'b0000;
    step;
    checks++;
    if (slv_addr !== 32'h8 || slv_valid !== 4'b0001) begin
      errors++;
      $display("FAIL tie2_first got addr=%h valid=%b want 8/0001", slv_addr, slv_valid);
    end
    step;
    checks++;
    if (dmem_ready !== 1'b1 || imem_ready !== 1'b0) begin
      errors++;
      $display("FAIL tie2_dresp got dready=%b iready=%b want 1/0", dmem_ready, imem_ready);
    end
    dmem_valid = 1'b0;
    step;
    step;
    checks++;
    if (slv_addr !== 32'h4 || slv_valid !== 4'b0001 || slv_wstrb !== 4'b0000) begin
      errors++;
      $display("FAIL tie2_second got addr=%h valid=%b wstrb=%b want 4/0001/0000", slv_addr, slv_valid, slv_wstrb);
    end
    step;
    checks++;
    if (imem_ready !== 1'b1 || imem_rdata !== bram_data) begin
      errors++;
      $display("FAIL tie2_iresp got ready=%b rdata=%h want 1/%h", imem_ready, imem_rdata, bram_data);
    end
    imem_valid = 1'b0;
    step;
  endtask

  task automatic test_unmapped;
    int e, vc; logic [3:0] seen; logic [31:0] rd; logic er, oth;
    do_req(1'b1, 32'h3000, 32'h0, 4'b0000, 0, e, vc, seen, rd, er, oth);
    checks++;
    if (e !== 1 || seen !== 4'b0000 || er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL unmapped got edges=%0d seen=%b err=%b rdata=%h want 1/0000/1/0", e, seen, er, rd);
    end
  endtask

  task automatic test_timeout;
    int e, vc; logic [3:0] seen; logic [31:0] rd; logic er, oth;
    ready_en = 4'b1011;
    do_req(1'b1, 32'h0200_BFF8, 32'h0, 4'b0000, 0, e, vc, seen, rd, er, oth);
    checks++;
    if (vc !== 8 || e !== 9 || seen !== 4'b0100 || er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL timeout got vcyc=%0d edges=%0d seen=%b err=%b rdata=%h want 8/9/0100/1/0", vc, e, seen, er, rd);
    end
    do_req(1'b1, 32'h0200_BFF8, 32'h0, 4'b0000, 8, e, vc, seen, rd, er, oth);
    checks++;
    if (vc !== 8 || e !== 9 || er !== 1'b0 || rd !== clint_data) begin
      errors++;
      $display("FAIL late_ready got vcyc=%0d edges=%0d err=%b rdata=%h want 8/9/0/%h", vc, e, er, rd, clint_data);
    end
    ready_en = 4'b1111;
  endtask

  task automatic test_boundaries;
    int e, vc; logic [3:0] seen; logic [31:0] rd; logic er, oth;
    do_req(1'b0, 32'h1FFC, 32'h0, 4'b0000, 0, e, vc, seen, rd, er, oth);
    checks++;
    if (e !== 2 || seen !== 4'b0001 || er !== 1'b0 || rd !== bram_data || oth !== 1'b0) begin
      errors++;
      $display("FAIL bound_1ffc got edges=%0d seen=%b err=%b rdata=%h other=%b want 2/0001/0/%h/0", e, seen, er, rd, oth, bram_data);
    end
    do_req(1'b1, 32'h2000, 32'h0, 4'b0000, 0, e, vc, seen, rd, er, oth);
    checks++;
    if (e !== 1 || seen !== 4'b0000 || er !== 1'b1) begin
      errors++;
      $display("FAIL bound_2000 got edges=%0d seen=%b err=%b want 1/0000/1", e, seen, er);
    end
    do_req(1'b1, 32'h0C00_0000, 32'h0, 4'b0000, 0, e, vc, seen, rd, er, oth);
    checks++;
    if (e !== 2 || seen !== 4'b1000 || er !== 1'b0 || rd !== plic_data) begin
      errors++;
      $display("FAIL bound_plic got edges=%0d seen=%b err=%b rdata=%h want 2/1000/0/%h", e, seen, er, rd, plic_data);
    end
    do_req(1'b0, 32'hFFFF_FFFC, 32'h0, 4'b0000, 0, e, vc, seen, rd, er, oth);
    checks++;
    if (e !== 1 || seen !== 4'b0000 || er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL bound_top got edges=%0d seen=%b err=%b rdata=%h want 1/0000/1/0", e, seen, er, rd);
    end
    do_req(1'b1, 32'h0100_0004, 32'h0, 4'b0000, 0, e, vc, seen, rd, er, oth);
    checks++;
    if (e !== 1 || seen !== 4'b0000 || er !== 1'b1) begin
      errors++;
      $display("FAIL bound_uart_top got edges=%0d seen=%b err=%b want 1/0000/1", e, seen, er);
    end
  endtask

  task automatic test_back_to_back;
    int e1, e2, vc; logic [3:0] seen; logic [31:0] rd; logic er, oth;
    do_req(1'b1, 32'h0100_0000, 32'h0, 4'b0000, 0, e1, vc, seen, rd, er, oth);
    do_req(1'b1, 32'h0200_0000, 32'h0, 4'b0000, 0, e2, vc, seen, rd, er, oth);
    checks++;
    if (e1 !== 2 || e2 !== 2 || seen !== 4'b0100 || rd !== clint_data) begin
      errors++;
      $display("FAIL back_to_back got edges=%0d/%0d seen=%b rdata=%h want 2/2/0100/%h", e1, e2, seen, rd, clint_data);
    end
  endtask

  task automatic test_reset_mid;
    ready_en = 4'b0000;
    imem_valid = 1'b1; imem_addr = 32'h100;
    step;
    checks++;
    if (slv_valid !== 4'b0001) begin
      errors++;
      $display("FAIL rstmid_access got %b want 0001", slv_valid);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({slv_valid, slv_wstrb, imem_ready, dmem_ready} !== 10'd0 || slv_addr !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_async got valid=%b ready=%b/%b addr=%h want 0", slv_valid, imem_ready, dmem_ready, slv_addr);
    end
    imem_valid = 1'b0;
    ready_en = 4'b1111;
    step;
    step;
    reset = 1'b1;
    step;
    checks++;
    if (imem_ready !== 1'b0 || slv_valid !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_silent got ready=%b valid=%b want 0/0000", imem_ready, slv_valid);
    end
    imem_valid = 1'b1; imem_addr = 32'h10;
    dmem_valid = 1'b1; dmem_addr = 32'h20; dmem_wstrb = 4'b0000;
    step;
    checks++;
    if (slv_addr !== 32'h10 || slv_valid !== 4'b0001) begin
      errors++;
      $display("FAIL rstmid_tie got addr=%h valid=%b want 10/0001", slv_addr, slv_valid);
    end
    step;
    checks++;
    if (imem_ready !== 1'b1 || imem_rdata !== bram_data || dmem_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_iresp got ready=%b rdata=%h dready=%b want 1/%h/0", imem_ready, imem_rdata, dmem_ready, bram_data);
    end
    imem_valid = 1'b0;
    step;
    step;
    step;
    checks++;
    if (dmem_ready !== 1'b1 || dmem_error !== 1'b0 || dmem_rdata !== bram_data) begin
      errors++;
      $display("FAIL rstmid_dresp got ready=%b err=%b rdata=%h want 1/0/%h", dmem_ready, dmem_error, dmem_rdata, bram_data);
    end
    dmem_valid = 1'b0;
    step;
  endtask

  initial begin
    #1;
    test_reset;
    test_single_read;
    test_tie;
    test_unmapped;
    test_timeout;
    test_boundaries;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
